// File: rtl/psum_help_arbiter_if.sv
// -----------------------------------------------------------------------------
// psum_help_arbiter_if
// Groups the request/release inputs and the psum mux control outputs of the
// psum help-channel arbiter.
//   MACARB_Req         : per-MAC drain request (level, held until granted)
// MACARB_Done        : per-MAC drain finished (pulse or level)
//   ARBCHN_IDMAC_Help  : packed MAC ID per help channel
//   ARBCHN_Switch      : per-channel enable (1 while BUSY)
//   ARBMAC_Grant       : per-MAC ownership flag
//   ARB_Idle           : no channel busy and no request pending (registered)
// Modports: master drives requests and observes the arbiter.
// Modports: slave is the arbiter side.
// -----------------------------------------------------------------------------
interface psum_help_arbiter_if #(
    parameter int MAC_NUM       = 32,
    parameter int MAC_NUM_WIDTH = 5,
    parameter int CHN_NUM       = 6
);
    logic [MAC_NUM-1:0]               MACARB_Req;
    logic [MAC_NUM-1:0]               MACARB_Done;
    logic [MAC_NUM_WIDTH*CHN_NUM-1:0] ARBCHN_IDMAC_Help;
    logic [CHN_NUM-1:0]               ARBCHN_Switch;
    logic [MAC_NUM-1:0]               ARBMAC_Grant;
    logic                             ARB_Idle;

    modport master (
        output MACARB_Req,
        output MACARB_Done,
        input  ARBCHN_IDMAC_Help,
        input  ARBCHN_Switch,
        input  ARBMAC_Grant,
        input  ARB_Idle
    );

    modport slave (
        input  MACARB_Req,
        input  MACARB_Done,
        output ARBCHN_IDMAC_Help,
        output ARBCHN_Switch,
        output ARBMAC_Grant,
        output ARB_Idle
    );
endinterface

// File: rtl/psum_help_arbiter.sv
// -----------------------------------------------------------------------------
// psum_help_arbiter
// Assigns MACs with pending partial sums to help channels. Each channel drives
// one input of a 2-input psum mux pair, where channels 2k and 2k+1 form pair k.
// At most one grant is made per cycle. The grant goes to the lowest IDLE channel.
// The winning MAC is chosen round-robin from ptr. A channel is released when
// its MAC reports done. All outputs come straight from registers.
// Ports:
//   clk     : clock
// rst_n   : synchronous active-low reset
//   CFG_Clr : synchronous flush, same effect as reset
//   arb_if  : request/done inputs, channel ID/enable, grant and idle outputs
// -----------------------------------------------------------------------------
module psum_help_arbiter #(
    parameter int MAC_NUM       = 32,
    parameter int MAC_NUM_WIDTH = 5,
    parameter int CHN_NUM       = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CFG_Clr,
    psum_help_arbiter_if.slave    arb_if
);

    typedef enum logic {
        CHN_IDLE = 1'b0,
        CHN_BUSY = 1'b1
    } chn_state_e;

    chn_state_e               r_state   [CHN_NUM];
    chn_state_e               w_state_nxt [CHN_NUM];
    logic [MAC_NUM_WIDTH-1:0] r_id      [CHN_NUM];
    logic [MAC_NUM_WIDTH-1:0] w_id_nxt  [CHN_NUM];
    logic [MAC_NUM-1:0]       r_grant;
    logic [MAC_NUM-1:0]       w_grant_nxt;
    logic [MAC_NUM_WIDTH-1:0] r_ptr;
    logic [MAC_NUM_WIDTH-1:0] w_ptr_nxt;
    logic                     r_idle;
    logic                     w_idle_nxt;

    logic [MAC_NUM-1:0]       w_elig;
    logic                     w_mac_found;
    logic [MAC_NUM_WIDTH-1:0] w_winner;
    logic                     w_chn_found;
    int unsigned              w_free_chn;

    // Winner search: first eligible MAC at or after ptr, wrapping at MAC_NUM.
    always_comb begin
        w_elig      = arb_if.MACARB_Req & ~r_grant;
        w_mac_found = 1'b0;
        w_winner    = '0;
        for (int unsigned i = 0; i < MAC_NUM; i++) begin
            int unsigned idx;
            idx = 32'(r_ptr) + i;
            if (idx >= MAC_NUM) idx = idx - MAC_NUM;
            if (!w_mac_found && w_elig[idx]) begin
                w_mac_found = 1'b1;
                w_winner    = idx[MAC_NUM_WIDTH-1:0];
            end
        end
    end

    // Target channel: lowest channel IDLE at the start of the cycle, so a
    // channel released this cycle only becomes grantable next cycle.
    always_comb begin
        w_chn_found = 1'b0;
        w_free_chn  = 0;
        for (int unsigned c = 0; c < CHN_NUM; c++) begin
            if (!w_chn_found && r_state[c] == CHN_IDLE) begin
                w_chn_found = 1'b1;
                w_free_chn  = c;
            end
        end
    end

    // Next state: releases first, then the single grant, then idle flag.
    always_comb begin
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        for (int unsigned c = 0; c < CHN_NUM; c++) begin
            w_state_nxt[c] = r_state[c];
            w_id_nxt[c]    = r_id[c];
            if (r_state[c] == CHN_BUSY && arb_if.MACARB_Done[r_id[c]]) begin
                w_state_nxt[c]       = CHN_IDLE;
                w_grant_nxt[r_id[c]] = 1'b0;
            end
        end
        if (w_mac_found && w_chn_found) begin
            w_state_nxt[w_free_chn] = CHN_BUSY;
            w_id_nxt[w_free_chn]    = w_winner;
            w_grant_nxt[w_winner]   = 1'b1;
            if (int'(w_winner) == MAC_NUM - 1)
                w_ptr_nxt = '0;
            else
                w_ptr_nxt = w_winner + MAC_NUM_WIDTH'(1);
        end
        w_idle_nxt = (arb_if.MACARB_Req == '0);
        for (int unsigned c = 0; c < CHN_NUM; c++) begin
            if (w_state_nxt[c] == CHN_BUSY) w_idle_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || CFG_Clr) begin
            for (int unsigned c = 0; c < CHN_NUM; c++) begin
                r_state[c] <= CHN_IDLE;
                r_id[c]    <= '0;
            end
            r_grant <= '0;
            r_ptr   <= '0;
            r_idle  <= 1'b1;
        end else begin
            for (int unsigned c = 0; c < CHN_NUM; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_id[c]    <= w_id_nxt[c];
            end
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idle  <= w_idle_nxt;
        end
    end

    always_comb begin
        arb_if.ARBCHN_IDMAC_Help = '0;
        arb_if.ARBCHN_Switch     = '0;
        for (int unsigned c = 0; c < CHN_NUM; c++) begin
            arb_if.ARBCHN_IDMAC_Help[c*MAC_NUM_WIDTH +: MAC_NUM_WIDTH] = r_id[c];
            arb_if.ARBCHN_Switch[c] = (r_state[c] == CHN_BUSY);
        end
    end

    assign arb_if.ARBMAC_Grant = r_grant;
    assign arb_if.ARB_Idle     = r_idle;

endmodule

// File: tb/tb_psum_help_arbiter.sv
// -----------------------------------------------------------------------------
// tb_psum_help_arbiter
// Directed testbench for psum_help_arbiter. It covers reset, single grant and
// release, fill and starve, release and re-grant, simultaneous events, done on
// an unassigned MAC, pointer wrap-around, and flush.
// -----------------------------------------------------------------------------
module tb_psum_help_arbiter;
    localparam int W = 5;

    logic clk;
    logic rst_n;
    logic CFG_Clr;
    int   n_pass;
    int   n_total;

    psum_help_arbiter_if #(.MAC_NUM(32), .MAC_NUM_WIDTH(5), .CHN_NUM(6)) bus ();

    psum_help_arbiter #(.MAC_NUM(32), .MAC_NUM_WIDTH(5), .CHN_NUM(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .CFG_Clr (CFG_Clr),
        .arb_if  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        CFG_Clr = 1'b1;
        tick();
        CFG_Clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            bus.MACARB_Req  = $urandom;
            bus.MACARB_Done = $urandom;
            tick();
        end
        n_total++; if (bus.ARBCHN_Switch !== 6'h00) $display("FAIL rst_switch got %h exp %h", bus.ARBCHN_Switch, 6'h00); else n_pass++;
        n_total++; if (bus.ARBCHN_IDMAC_Help !== 30'h0) $display("FAIL rst_ids got %h exp %h", bus.ARBCHN_IDMAC_Help, 30'h0); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0) $display("FAIL rst_grant got %h exp %h", bus.ARBMAC_Grant, 32'h0); else n_pass++;
        n_total++; if (bus.ARB_Idle !== 1'b1) $display("FAIL rst_idle got %b exp 1", bus.ARB_Idle); else n_pass++;
        bus.MACARB_Req  = '0;
        bus.MACARB_Done = '0;
        rst_n = 1'b1;
        tick();
        tick();
        n_total++; if (bus.ARBCHN_Switch !== 6'h00) $display("FAIL post_rst_switch got %h exp %h", bus.ARBCHN_Switch, 6'h00); else n_pass++;
        n_total++; if (bus.ARBCHN_IDMAC_Help !== 30'h0) $display("FAIL post_rst_ids got %h exp %h", bus.ARBCHN_IDMAC_Help, 30'h0); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0) $display("FAIL post_rst_grant got %h exp %h", bus.ARBMAC_Grant, 32'h0); else n_pass++;
        n_total++; if (bus.ARB_Idle !== 1'b1) $display("FAIL post_rst_idle got %b exp 1", bus.ARB_Idle); else n_pass++;
    endtask

    task automatic test_single();
        bus.MACARB_Req = 32'h0000_0080;
        tick();
        n_total++; if (bus.ARBCHN_Switch !== 6'b000001) $display("FAIL single_switch got %b exp %b", bus.ARBCHN_Switch, 6'b000001); else n_pass++;
        n_total++; if (bus.ARBCHN_IDMAC_Help[0 +: W] !== 5'd7) $display("FAIL single_id0 got %0d exp 7", bus.ARBCHN_IDMAC_Help[0 +: W]); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0000_0080) $display("FAIL single_grant got %h exp %h", bus.ARBMAC_Grant, 32'h80); else n_pass++;
        n_total++; if (bus.ARB_Idle !== 1'b0) $display("FAIL single_idle got %b exp 0", bus.ARB_Idle); else n_pass++;
        bus.MACARB_Req = '0;
        tick();
        tick();
        bus.MACARB_Done = 32'h0000_0080;
        tick();
        bus.MACARB_Done = '0;
        n_total++; if (bus.ARBCHN_Switch !== 6'b000000) $display("FAIL release_switch got %b exp %b", bus.ARBCHN_Switch, 6'b0); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0) $display("FAIL release_grant got %h exp %h", bus.ARBMAC_Grant, 32'h0); else n_pass++;
        n_total++; if (bus.ARB_Idle !== 1'b1) $display("FAIL release_idle got %b exp 1", bus.ARB_Idle); else n_pass++;
        n_total++; if (bus.ARBCHN_IDMAC_Help[0 +: W] !== 5'd7) $display("FAIL idle_id_hold got %0d exp 7", bus.ARBCHN_IDMAC_Help[0 +: W]); else n_pass++;
    endtask

    task automatic test_fill();
        clr_pulse();
        bus.MACARB_Req = '1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_total++; if (bus.ARBCHN_Switch !== 6'((1 << k) - 1)) $display("FAIL fill_switch_%0d got %b exp %b", k, bus.ARBCHN_Switch, 6'((1 << k) - 1)); else n_pass++;
            n_total++; if (bus.ARBCHN_IDMAC_Help[(k-1)*W +: W] !== 5'(k - 1)) $display("FAIL fill_id_%0d got %0d exp %0d", k, bus.ARBCHN_IDMAC_Help[(k-1)*W +: W], k - 1); else n_pass++;
            n_total++; if (bus.ARBMAC_Grant !== 32'((1 << k) - 1)) $display("FAIL fill_grant_%0d got %h exp %h", k, bus.ARBMAC_Grant, 32'((1 << k) - 1)); else n_pass++;
        end
        tick();
        n_total++; if (bus.ARBCHN_Switch !== 6'h3f) $display("FAIL starve_switch got %h exp %h", bus.ARBCHN_Switch, 6'h3f); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0000_003f) $display("FAIL starve_grant got %h exp %h", bus.ARBMAC_Grant, 32'h3f); else n_pass++;
        n_total++; if (bus.ARB_Idle !== 1'b0) $display("FAIL starve_idle got %b exp 0", bus.ARB_Idle); else n_pass++;
    endtask

    task automatic test_release_regrant();
        bus.MACARB_Done = 32'h0000_0004;
        tick();
        bus.MACARB_Done = '0;
        n_total++; if (bus.ARBCHN_Switch !== 6'b111011) $display("FAIL rel2_switch got %b exp %b", bus.ARBCHN_Switch, 6'b111011); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0000_003b) $display("FAIL rel2_grant got %h exp %h", bus.ARBMAC_Grant, 32'h3b); else n_pass++;
        tick();
        n_total++; if (bus.ARBCHN_Switch !== 6'h3f) $display("FAIL regrant_switch got %h exp %h", bus.ARBCHN_Switch, 6'h3f); else n_pass++;
        n_total++; if (bus.ARBCHN_IDMAC_Help[2*W +: W] !== 5'd6) $display("FAIL regrant_id2 got %0d exp 6", bus.ARBCHN_IDMAC_Help[2*W +: W]); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0000_007b) $display("FAIL regrant_grant got %h exp %h", bus.ARBMAC_Grant, 32'h7b); else n_pass++;
    endtask

    task automatic test_simultaneous();
        // channels hold MACs 0,1,6,3,4,5
        bus.MACARB_Req  = 32'h0000_0200;
        bus.MACARB_Done = 32'h0000_0012;
        tick();
        bus.MACARB_Done = '0;
        n_total++; if (bus.ARBCHN_Switch !== 6'b101101) $display("FAIL dual_rel_switch got %b exp %b", bus.ARBCHN_Switch, 6'b101101); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0000_0069) $display("FAIL dual_rel_grant got %h exp %h", bus.ARBMAC_Grant, 32'h69); else n_pass++;
        tick();
        bus.MACARB_Req = '0;
        n_total++; if (bus.ARBCHN_Switch !== 6'b101111) $display("FAIL mac9_switch got %b exp %b", bus.ARBCHN_Switch, 6'b101111); else n_pass++;
        n_total++; if (bus.ARBCHN_IDMAC_Help[1*W +: W] !== 5'd9) $display("FAIL mac9_id1 got %0d exp 9", bus.ARBCHN_IDMAC_Help[1*W +: W]); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0000_0269) $display("FAIL mac9_grant got %h exp %h", bus.ARBMAC_Grant, 32'h269); else n_pass++;
        // done on a MAC that owns no channel
        bus.MACARB_Done = 32'h0010_0000;
        tick();
        bus.MACARB_Done = '0;
        n_total++; if (bus.ARBCHN_Switch !== 6'b101111) $display("FAIL unassigned_done_switch got %b exp %b", bus.ARBCHN_Switch, 6'b101111); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0000_0269) $display("FAIL unassigned_done_grant got %h exp %h", bus.ARBMAC_Grant, 32'h269); else n_pass++;
        // req and done together on an owning MAC
        bus.MACARB_Req  = 32'h0000_0200;
        bus.MACARB_Done = 32'h0000_0200;
        tick();
        bus.MACARB_Done = '0;
        n_total++; if (bus.ARBCHN_Switch !== 6'b101101) $display("FAIL reqdone_switch got %b exp %b", bus.ARBCHN_Switch, 6'b101101); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0000_0069) $display("FAIL reqdone_grant got %h exp %h", bus.ARBMAC_Grant, 32'h69); else n_pass++;
        tick();
        bus.MACARB_Req = '0;
        n_total++; if (bus.ARBCHN_Switch !== 6'b101111) $display("FAIL reqdone_regrant_switch got %b exp %b", bus.ARBCHN_Switch, 6'b101111); else n_pass++;
        n_total++; if (bus.ARBCHN_IDMAC_Help[1*W +: W] !== 5'd9) $display("FAIL reqdone_regrant_id1 got %0d exp 9", bus.ARBCHN_IDMAC_Help[1*W +: W]); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0000_0269) $display("FAIL reqdone_regrant_grant got %h exp %h", bus.ARBMAC_Grant, 32'h269); else n_pass++;
    endtask

    task automatic test_wrap();
        clr_pulse();
        bus.MACARB_Req = 32'h4000_0000;
        tick();
        n_total++; if (bus.ARBCHN_IDMAC_Help[0 +: W] !== 5'd30) $display("FAIL wrap_id0 got %0d exp 30", bus.ARBCHN_IDMAC_Help[0 +: W]); else n_pass++;
        bus.MACARB_Req = 32'h8000_0001;
        tick();
        n_total++; if (bus.ARBCHN_IDMAC_Help[1*W +: W] !== 5'd31) $display("FAIL wrap_id1 got %0d exp 31", bus.ARBCHN_IDMAC_Help[1*W +: W]); else n_pass++;
        tick();
        n_total++; if (bus.ARBCHN_IDMAC_Help[2*W +: W] !== 5'd0) $display("FAIL wrap_id2 got %0d exp 0", bus.ARBCHN_IDMAC_Help[2*W +: W]); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'hc000_0001) $display("FAIL wrap_grant got %h exp %h", bus.ARBMAC_Grant, 32'hc0000001); else n_pass++;
        bus.MACARB_Req  = '0;
        bus.MACARB_Done = 32'h0000_0001;
        tick();
        bus.MACARB_Done = '0;
        n_total++; if (bus.ARBCHN_Switch !== 6'b000011) $display("FAIL wrap_rel_switch got %b exp %b", bus.ARBCHN_Switch, 6'b000011); else n_pass++;
        // ptr is 1, so MAC 1 must beat MAC 0
        bus.MACARB_Req = 32'h0000_0003;
        tick();
        bus.MACARB_Req = '0;
        n_total++; if (bus.ARBCHN_IDMAC_Help[2*W +: W] !== 5'd1) $display("FAIL wrap_ptr_id2 got %0d exp 1", bus.ARBCHN_IDMAC_Help[2*W +: W]); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'hc000_0002) $display("FAIL wrap_ptr_grant got %h exp %h", bus.ARBMAC_Grant, 32'hc0000002); else n_pass++;
    endtask

    task automatic test_flush();
        clr_pulse();
        bus.MACARB_Req = '1;
        repeat (3) tick();
        n_total++; if (bus.ARBCHN_Switch !== 6'b000111) $display("FAIL flush_pre_switch got %b exp %b", bus.ARBCHN_Switch, 6'b000111); else n_pass++;
        CFG_Clr = 1'b1;
        tick();
        CFG_Clr = 1'b0;
        bus.MACARB_Req = '0;
        n_total++; if (bus.ARBCHN_Switch !== 6'h00) $display("FAIL flush_switch got %h exp %h", bus.ARBCHN_Switch, 6'h00); else n_pass++;
        n_total++; if (bus.ARBCHN_IDMAC_Help !== 30'h0) $display("FAIL flush_ids got %h exp %h", bus.ARBCHN_IDMAC_Help, 30'h0); else n_pass++;
        n_total++; if (bus.ARBMAC_Grant !== 32'h0) $display("FAIL flush_grant got %h exp %h", bus.ARBMAC_Grant, 32'h0); else n_pass++;
        n_total++; if (bus.ARB_Idle !== 1'b1) $display("FAIL flush_idle got %b exp 1", bus.ARB_Idle); else n_pass++;
        tick();
        n_total++; if (bus.ARB_Idle !== 1'b1) $display("FAIL flush_idle_hold got %b exp 1", bus.ARB_Idle); else n_pass++;
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        rst_n           = 1'b0;
        CFG_Clr         = 1'b0;
        bus.MACARB_Req  = '0;
        bus.MACARB_Done = '0;
        test_reset();
        test_single();
        test_fill();
        test_release_regrant();
        test_simultaneous();
        test_wrap();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
